k6502_timing: RTL and testbench
===============================

Name: k6502_timing

Overview:
- Cycle sequencer for the k6502 core.
- Tracks the T-state of the current instruction and sequences the 7-cycle reset and interrupt (NMI/IRQ) entry.
- Drives the address-register load strobes (adl_abl, adh_abh), address source select, R/W, IR load, PC increment and SP decrement for the datapath.
- The opcode decoder reports end of instruction via instr_done; this block decides what the next cycle is.

Parameters:
- T_MAX, 7, last legal EXEC t_state before the watchdog forces a fetch.

Ports:
- ph0  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rdy  in  1  ready; 0 stalls read cycles.
- nmi_n  in  1  NMI request, falling-edge sensitive.
- irq_n  in  1  IRQ request, level-sensitive, active low.
- i_flag  in  1  processor I flag; 1 masks IRQ.
- instr_done  in  1  decoder: current EXEC cycle is the last of the instruction.
- t_state  out  3  cycle index within instruction/sequence.
- sync  out  1  opcode fetch cycle.
- rw  out  1  1=read, 0=write.
- ab_src  out  2  address source: 0 PC, 1 vector lo, 2 vector hi, 3 stack.
- vector_sel  out  2  0 reset (FFFC), 1 NMI (FFFA), 2 IRQ (FFFE).
- adl_abl, adh_abh  out  1 each  load ABL/ABH this cycle.
- ir_load  out  1  load IR from data bus.
- pc_inc  out  1  increment PC.
- sp_dec  out  1  decrement SP.
- set_i  out  1  set I flag.
- int_active  out  1  reset/interrupt sequence in progress.
- seq_err  out  1  watchdog pulse.

Behaviour:
- States: RST_SEQ, FETCH, EXEC, INT_SEQ. The state, t_state, vector_sel, nmi_pending and nmi_n_q are registered. All other outputs are combinational from the registered state and rdy.
- Reset (any cycle, any state, including mid-sequence):
  - state=RST_SEQ, t_state=0, vector_sel=0, nmi_pending=0, nmi_n_q=1.
  - While reset is held: rw=1, and sync, ir_load, pc_inc, sp_dec, set_i, adl_abl, adh_abh and seq_err are all 0. int_active=1.
- RST_SEQ and INT_SEQ: t_state runs 0..6, one step per advancing cycle.
  - t0, t1: ab_src=PC, rw=1.
  - t2, t3, t4: ab_src=stack, sp_dec=1. rw=0 in INT_SEQ; rw=1 in RST_SEQ (pushes suppressed).
  - t5: ab_src=1, set_i=1.
  - t6: ab_src=2.
  - After t6: FETCH.
  - int_active=1 throughout both sequences.
- FETCH: t_state=0, sync=1, ab_src=PC, rw=1, ir_load=1, pc_inc=1. Next state is EXEC with t_state=1.
- EXEC: t_state increments each advancing cycle; ab_src=PC, rw=1. The datapath decoder owns all other controls. When instr_done=1, the next state is chosen by priority:
  1. nmi_pending: INT_SEQ, vector_sel=1, clear nmi_pending.
  2. irq_n=0 and i_flag=0: INT_SEQ, vector_sel=2.
  3. Otherwise: FETCH.
- Watchdog: in EXEC with t_state=T_MAX and instr_done=0, seq_err=1 for that cycle, and the sequencer takes the instr_done path.
- adl_abl = adh_abh = 1 in every non-reset, non-stalled cycle.
- Stall: rdy=0 in a cycle with rw=1 freezes state and t_state. It also forces ir_load, pc_inc, sp_dec, set_i, adl_abl and adh_abh to 0. Write cycles (rw=0) ignore rdy.
- NMI edge detection:
  - nmi_n_q <= nmi_n every cycle.
  - nmi_n_q=1 and nmi_n=0 sets nmi_pending.
  - If a new edge coincides with the clear, pending stays set.
- NMI hijack: in INT_SEQ with vector_sel=2, at an advancing t4 with nmi_pending=1, vector_sel becomes 1 from t5 and nmi_pending clears.
- IRQ sampling: irq_n is sampled only at instr_done, so it must be held low. BRK is handled by the decoder, not here.

Test Plan:
- Reset held for 3 cycles, then released with rdy=1: t_state 0..6 with rw=1 throughout and sp_dec on t2–t4; ab_src 1 at t5, 2 at t6; vector_sel=0; sync=1 on cycle 8.
- Fetch, then instr_done at t_state=2: sync pattern 1,0,0,1. ir_load and pc_inc asserted only in the FETCH cycles.
- irq_n=0 with i_flag=0 at instr_done: INT_SEQ with rw=0 on t2–t4, vector_sel=2, set_i at t5. Repeating with i_flag=1 goes straight to FETCH.
- NMI pulse (1 cycle low) mid-instruction, with irq_n=0: the NMI is taken at instr_done with vector_sel=1 and nmi_pending clears. A second NMI pulse during the IRQ sequence at t3 switches vector_sel to 1 at t5.
- rdy=0 for 4 cycles during FETCH: t_state holds at 0 and ir_load=0 while stalled. rdy=0 during INT_SEQ t2 does not stall.
- instr_done never asserted: seq_err pulses at t_state=7 and the next cycle is FETCH. Reset asserted at INT_SEQ t3 gives RST_SEQ t0 on the next cycle.

Source files
------------

// File: rtl/k6502_timing.sv
// k6502_timing: cycle sequencer for the k6502 core.
// Tracks the T-state of each instruction, runs the 7-cycle reset/interrupt
// entry sequence and drives the per-cycle strobes the datapath needs.
module k6502_timing #(
   parameter int T_MAX = 7
) (
   input  logic       ph0,
   input  logic       reset,
   input  logic       rdy,
   input  logic       nmi_n,
   input  logic       irq_n,
   input  logic       i_flag,
   input  logic       instr_done,
   output logic [2:0] t_state,
   output logic       sync,
   output logic       rw,
   output logic [1:0] ab_src,
   output logic [1:0] vector_sel,
   output logic       adl_abl,
   output logic       adh_abh,
   output logic       ir_load,
   output logic       pc_inc,
   output logic       sp_dec,
   output logic       set_i,
   output logic       int_active,
   output logic       seq_err
);

   localparam logic [2:0] T_LAST = 3'(T_MAX);

   localparam logic [1:0] AB_PC    = 2'd0;
   localparam logic [1:0] AB_VEC_L = 2'd1;
   localparam logic [1:0] AB_VEC_H = 2'd2;
   localparam logic [1:0] AB_STACK = 2'd3;

   localparam logic [1:0] VEC_RESET = 2'd0;
   localparam logic [1:0] VEC_NMI   = 2'd1;
   localparam logic [1:0] VEC_IRQ   = 2'd2;

   typedef enum logic [1:0] {
      RST_SEQ,
      FETCH,
      EXEC,
      INT_SEQ
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_t_state;
   logic [2:0] w_t_state_nxt;
   logic [1:0] r_vector_sel;
   logic [1:0] w_vector_sel_nxt;
   logic       r_nmi_pending;
   logic       r_nmi_n_q;
   logic       w_nmi_edge;
   logic       w_nmi_clear;
   logic       w_is_seq;
   logic       w_push_cycle;
   logic       w_advance;
   logic       w_end_instr;

   // Stack-push cycles of the entry sequence; only INT_SEQ actually writes.
   assign w_is_seq     = (r_state == RST_SEQ) || (r_state == INT_SEQ);
   assign w_push_cycle = w_is_seq && (r_t_state >= 3'd2) && (r_t_state <= 3'd4);
   assign rw           = !(!reset && (r_state == INT_SEQ) && w_push_cycle);
   // A cycle advances unless in reset or a read cycle is stalled by rdy.
   assign w_advance    = !reset && (rdy || !rw);
   assign w_end_instr  = instr_done || (r_t_state == T_LAST);
   assign w_nmi_edge   = r_nmi_n_q && !nmi_n;

   // Per-cycle datapath strobes decoded from the registered state.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      t_state    = r_t_state;
      vector_sel = r_vector_sel;
      sync       = 1'b0;
      ab_src     = AB_PC;
      adl_abl    = w_advance;
      adh_abh    = w_advance;
      ir_load    = 1'b0;
      pc_inc     = 1'b0;
      sp_dec     = 1'b0;
      set_i      = 1'b0;
      int_active = reset;
      seq_err    = 1'b0;
      if (!reset) begin
         unique case (r_state)
            RST_SEQ, INT_SEQ: begin
               int_active = 1'b1;
               if (w_push_cycle) begin
                  ab_src = AB_STACK;
                  sp_dec = w_advance;
               end else if (r_t_state == 3'd5) begin
                  ab_src = AB_VEC_L;
                  set_i  = w_advance;
               end else if (r_t_state == 3'd6) begin
                  ab_src = AB_VEC_H;
               end
            end
            FETCH: begin
               sync    = 1'b1;
               ir_load = w_advance;
               pc_inc  = w_advance;
            end
            EXEC: begin
               seq_err = (r_t_state == T_LAST) && !instr_done;
            end
            default: ;
         endcase
      end
   end

   // Next-state selection, including interrupt priority and NMI hijack.
   always_comb begin
      w_state_nxt      = r_state;
      w_t_state_nxt    = r_t_state;
      w_vector_sel_nxt = r_vector_sel;
      w_nmi_clear      = 1'b0;
      if (w_advance) begin
         unique case (r_state)
            RST_SEQ, INT_SEQ: begin
               if (r_t_state == 3'd6) begin
                  w_state_nxt   = FETCH;
                  w_t_state_nxt = 3'd0;
               end else begin
                  w_t_state_nxt = r_t_state + 3'd1;
               end
               // A late NMI takes over an IRQ entry before the vector fetch.
               if ((r_state == INT_SEQ) && (r_vector_sel == VEC_IRQ) &&
                   (r_t_state == 3'd4) && r_nmi_pending) begin
                  w_vector_sel_nxt = VEC_NMI;
                  w_nmi_clear      = 1'b1;
               end
            end
            FETCH: begin
               w_state_nxt   = EXEC;
               w_t_state_nxt = 3'd1;
            end
            EXEC: begin
               if (w_end_instr) begin
                  w_t_state_nxt = 3'd0;
                  if (r_nmi_pending) begin
                     w_state_nxt      = INT_SEQ;
                     w_vector_sel_nxt = VEC_NMI;
                     w_nmi_clear      = 1'b1;
                  end else if (!irq_n && !i_flag) begin
                     w_state_nxt      = INT_SEQ;
                     w_vector_sel_nxt = VEC_IRQ;
                  end else begin
                     w_state_nxt = FETCH;
                  end
               end else begin
                  w_t_state_nxt = r_t_state + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // State registers; a new NMI edge wins over a simultaneous clear.
   always_ff @(posedge ph0) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) begin
         r_state       <= RST_SEQ;
         r_t_state     <= 3'd0;
         r_vector_sel  <= VEC_RESET;
         r_nmi_pending <= 1'b0;
         r_nmi_n_q     <= 1'b1;
      end else begin
         r_state       <= w_state_nxt;
         r_t_state     <= w_t_state_nxt;
         r_vector_sel  <= w_vector_sel_nxt;
         r_nmi_pending <= (r_nmi_pending && !w_nmi_clear) || w_nmi_edge;
         r_nmi_n_q     <= nmi_n;
      end
   end

endmodule

// File: tb/tb_k6502_timing.sv
// tb_k6502_timing: directed scoreboard bench for the k6502 cycle sequencer.
module tb_k6502_timing;

   typedef struct packed {
      logic [2:0] t;
      logic       sync;
      logic       rw;
      logic [1:0] ab;
      logic [1:0] vsel;
      logic       adl;
      logic       adh;
      logic       ir;
      logic       pc;
      logic       sp;
      logic       seti;
      logic       ia;
      logic       err;
   } exp_t;

   logic       ph0;
   logic       reset;
   logic       rdy;
   logic       nmi_n;
   logic       irq_n;
   logic       i_flag;
   logic       instr_done;
   logic [2:0] t_state;
   logic       sync;
   logic       rw;
   logic [1:0] ab_src;
   logic [1:0] vector_sel;
   logic       adl_abl;
   logic       adh_abh;
   logic       ir_load;
   logic       pc_inc;
   logic       sp_dec;
   logic       set_i;
   logic       int_active;
   logic       seq_err;

   int n_checks = 0;
   int n_pass   = 0;

   exp_t  exp_q[$];
   string tag_q[$];

   k6502_timing #(.T_MAX(7)) dut (
      .ph0(ph0), .reset(reset), .rdy(rdy), .nmi_n(nmi_n), .irq_n(irq_n),
      .i_flag(i_flag), .instr_done(instr_done), .t_state(t_state),
      .sync(sync), .rw(rw), .ab_src(ab_src), .vector_sel(vector_sel),
      .adl_abl(adl_abl), .adh_abh(adh_abh), .ir_load(ir_load),
      .pc_inc(pc_inc), .sp_dec(sp_dec), .set_i(set_i),
      .int_active(int_active), .seq_err(seq_err)
   );

   initial ph0 = 1'b0;
   always #5 ph0 = ~ph0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", tag, obs[16:0], exp[16:0]);
   endtask

   // Expected outputs of an entry-sequence cycle.
   function automatic exp_t e_seq(input bit is_int, input int t, input logic [1:0] vs);
      exp_t e;
      e      = '0;
      e.t    = t[2:0];
      e.rw   = !(is_int && t >= 2 && t <= 4);
      e.ab   = (t < 2) ? 2'd0 : (t <= 4) ? 2'd3 : (t == 5) ? 2'd1 : 2'd2;
      e.vsel = vs;
      e.adl  = 1'b1;
      e.adh  = 1'b1;
      e.sp   = (t >= 2 && t <= 4);
      e.seti = (t == 5);
      e.ia   = 1'b1;
      return e;
   endfunction

   function automatic exp_t e_fetch(input logic [1:0] vs, input bit stalled);
      exp_t e;
      e      = '0;
      e.sync = 1'b1;
      e.rw   = 1'b1;
      e.vsel = vs;
      e.adl  = !stalled;
      e.adh  = !stalled;
      e.ir   = !stalled;
      e.pc   = !stalled;
      return e;
   endfunction

   function automatic exp_t e_exec(input int t, input logic [1:0] vs, input bit err);
      exp_t e;
      e      = '0;
      e.t    = t[2:0];
      e.rw   = 1'b1;
      e.vsel = vs;
      e.adl  = 1'b1;
      e.adh  = 1'b1;
      e.err  = err;
      return e;
   endfunction

   function automatic exp_t e_rst(input int t, input logic [1:0] vs);
      exp_t e;
      e      = '0;
      e.t    = t[2:0];
      e.rw   = 1'b1;
      e.vsel = vs;
      e.ia   = 1'b1;
      return e;
   endfunction

   // Drive one cycle's inputs on the falling edge and queue its expectation.
   task automatic cyc(input string tag, input exp_t e, input logic dn = 1'b0,
                      input logic irq = 1'b1, input logic nn = 1'b1,
                      input logic rd = 1'b1, input logic ifl = 1'b0,
                      input logic rst = 1'b0);
      @(negedge ph0);
      reset      = rst;
      rdy        = rd;
      nmi_n      = nn;
      irq_n      = irq;
      i_flag     = ifl;
      instr_done = dn;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic run_seq(input string tag, input bit is_int, input logic [1:0] vs);
      for (int t = 0; t < 7; t++) cyc($sformatf("%s_t%0d", tag, t), e_seq(is_int, t, vs));
   endtask

   // Monitor: compare outputs a little after inputs settle, well before the rising edge.
   always @(negedge ph0) begin
      exp_t  e;
      exp_t  o;
      string tg;
      #2;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tg = tag_q.pop_front();
         o = {t_state, sync, rw, ab_src, vector_sel, adl_abl, adh_abh,
              ir_load, pc_inc, sp_dec, set_i, int_active, seq_err};
         check(tg, {15'b0, o}, {15'b0, e});
      end
   end

   initial begin
      reset = 1'b1; rdy = 1'b1; nmi_n = 1'b1; irq_n = 1'b1;
      i_flag = 1'b0; instr_done = 1'b0;

      // Reset held, then the 7-cycle reset sequence and first fetch.
      for (int i = 0; i < 3; i++)
         cyc($sformatf("rst_hold%0d", i), e_rst(0, 2'd0), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      run_seq("rstseq", 1'b0, 2'd0);

      // Short instruction: sync 1,0,0,1.
      cyc("fetch_a", e_fetch(2'd0, 1'b0));
      cyc("exec_a1", e_exec(1, 2'd0, 1'b0));
      cyc("exec_a2", e_exec(2, 2'd0, 1'b0), 1'b1);
      cyc("fetch_b", e_fetch(2'd0, 1'b0));

      // IRQ taken with I clear.
      cyc("exec_irq", e_exec(1, 2'd0, 1'b0), 1'b1, 1'b0);
      run_seq("irqseq", 1'b1, 2'd2);
      cyc("fetch_c", e_fetch(2'd2, 1'b0));

      // IRQ masked with I set.
      cyc("exec_mask", e_exec(1, 2'd2, 1'b0), 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      cyc("fetch_d", e_fetch(2'd2, 1'b0));

      // NMI pulse mid-instruction beats a pending IRQ.
      cyc("exec_nmi1", e_exec(1, 2'd2, 1'b0), 1'b0, 1'b1, 1'b0);
      cyc("exec_nmi2", e_exec(2, 2'd2, 1'b0), 1'b1, 1'b0);
      run_seq("nmiseq", 1'b1, 2'd1);
      cyc("fetch_e", e_fetch(2'd1, 1'b0));
      cyc("exec_nmiclr", e_exec(1, 2'd1, 1'b0), 1'b1);
      cyc("fetch_f", e_fetch(2'd1, 1'b0));

      // IRQ entry hijacked by an NMI pulse at t3.
      cyc("exec_irq2", e_exec(1, 2'd1, 1'b0), 1'b1, 1'b0);
      cyc("hij_t0", e_seq(1'b1, 0, 2'd2));
      cyc("hij_t1", e_seq(1'b1, 1, 2'd2));
      cyc("hij_t2", e_seq(1'b1, 2, 2'd2));
      cyc("hij_t3", e_seq(1'b1, 3, 2'd2), 1'b0, 1'b1, 1'b0);
      cyc("hij_t4", e_seq(1'b1, 4, 2'd2));
      cyc("hij_t5", e_seq(1'b1, 5, 2'd1));
      cyc("hij_t6", e_seq(1'b1, 6, 2'd1));
      cyc("fetch_g", e_fetch(2'd1, 1'b0));
      cyc("exec_hijclr", e_exec(1, 2'd1, 1'b0), 1'b1);

      // Stall during fetch; rdy ignored on a push cycle.
      for (int i = 0; i < 4; i++)
         cyc($sformatf("stall%0d", i), e_fetch(2'd1, 1'b1), 1'b0, 1'b1, 1'b1, 1'b0);
      cyc("fetch_h", e_fetch(2'd1, 1'b0));
      cyc("exec_irq3", e_exec(1, 2'd1, 1'b0), 1'b1, 1'b0);
      cyc("wst_t0", e_seq(1'b1, 0, 2'd2));
      cyc("wst_t1", e_seq(1'b1, 1, 2'd2));
      cyc("wst_t2", e_seq(1'b1, 2, 2'd2), 1'b0, 1'b1, 1'b1, 1'b0);
      for (int t = 3; t < 7; t++) cyc($sformatf("wst_t%0d", t), e_seq(1'b1, t, 2'd2));
      cyc("fetch_i", e_fetch(2'd2, 1'b0));

      // Watchdog: instr_done never comes.
      for (int t = 1; t < 7; t++) cyc($sformatf("wd_t%0d", t), e_exec(t, 2'd2, 1'b0));
      cyc("wd_t7", e_exec(7, 2'd2, 1'b1));
      cyc("fetch_j", e_fetch(2'd2, 1'b0));

      // Reset in the middle of an interrupt sequence.
      cyc("exec_irq4", e_exec(1, 2'd2, 1'b0), 1'b1, 1'b0);
      cyc("mid_t0", e_seq(1'b1, 0, 2'd2));
      cyc("mid_t1", e_seq(1'b1, 1, 2'd2));
      cyc("mid_t2", e_seq(1'b1, 2, 2'd2));
      cyc("mid_rst", e_rst(3, 2'd2), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      run_seq("rstseq2", 1'b0, 2'd0);
      cyc("fetch_k", e_fetch(2'd0, 1'b0));

      repeat (3) @(negedge ph0);
      #4;
      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
